bp_direction_ctrl: RTL
======================

# bp_direction_ctrl

Direction-prediction controller that drives the 2-bit saturating counter array (pattern history table) and sits between fetch and the execute-stage branch resolution. It forms the table index from the fetch PC (optionally XOR global history) and registers the taken/not-taken prediction. It holds in-flight predictions in order until resolution, then issues increment/decrement strobes and flags mispredicts. After reset it sweeps the counter array to the weakly-not-taken state.

## Interface
Parameters:
- S_INDEX, 3, counter-array index width; NUM_SETS = 2**S_INDEX
- GHR_W, S_INDEX, global history register width (used only with GSHARE_EN)
- DEPTH, 4, pending-prediction FIFO entries (power of two)
- PC_LSB, 2, lowest PC bit used for indexing

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_valid  in  1  fetch presents a branch PC
- fetch_pc  in  32  branch PC
- fetch_ready  out  1  lookup accepted this cycle when fetch_valid && fetch_ready
- pred_valid  out  1  registered prediction valid
- pred_taken  out  1  registered prediction
- resolve_valid  in  1  oldest in-flight branch resolved
- resolve_taken  in  1  actual outcome
- mispredict  out  1  one-cycle pulse, registered
- resolve_err  out  1  sticky: resolve with empty FIFO
- ctr_index  out  S_INDEX  to counter array index
- ctr_increment  out  1  to counter array
- ctr_decrement  out  1  to counter array
- ctr_reset  out  1  to counter array reset (per-index init)
- ctr_out  in  2  counter value at ctr_index (combinational read)

## Operation
- States: INIT, RUN. Reset enters INIT with sweep = 0.
- INIT: ctr_reset = 1, ctr_index = sweep, sweep++ each cycle. After index NUM_SETS-1, go to RUN. fetch_ready = 0, resolve ignored (resolve_err unchanged).
- RUN priority per cycle: resolve > lookup.
- Resolve (resolve_valid && FIFO non-empty): ctr_index = head.index; ctr_increment = resolve_taken, ctr_decrement = !resolve_taken; pop head. The counter array saturates; this block does not check saturation.
- Mispredict (resolve_taken != head.pred): flush the entire FIFO (all younger entries are wrong-path). With GSHARE_EN, restore ghr <= {head.ghr[GHR_W-2:0], resolve_taken}. Assert mispredict next cycle.
- Correct resolve: FIFO and ghr otherwise unchanged.
- Resolve with FIFO empty: no strobes, resolve_err <= 1 (cleared only by reset).
- fetch_ready = (state == RUN) && !FIFO full && !(resolve_valid && FIFO non-empty).
- Lookup on accept: ctr_index = lookup index; taken = ctr_out[1]. Push {index, taken, ghr snapshot (pre-update)}. With GSHARE_EN, ghr <= {ghr[GHR_W-2:0], taken}. Register pred_valid = 1 and pred_taken = taken.
- When neither lookup nor resolve is active, ctr_index = lookup index and all strobes are 0.
- Reset mid-operation: FIFO emptied, ghr = 0, pred_valid = mispredict = resolve_err = 0, re-enter INIT from sweep = 0.

## Timing
- Lookup accepted at cycle T: pred_valid/pred_taken are valid at T+1 for one cycle.
- Resolve at T: strobes combinational at T; counter updates at the T+1 edge; mispredict high during T+1.
- A lookup of the same index at T+1 sees the updated counter.
- fetch_ready depends combinationally on resolve_valid.
- INIT lasts exactly NUM_SETS cycles after reset deasserts. The first fetch_ready=1 is in cycle NUM_SETS+1.
- FIFO full with a concurrent resolve: resolve proceeds, lookup stalls; ready returns the next cycle.

## Configuration
- BP_GSHARE_EN defined: index = fetch_pc[PC_LSB +: S_INDEX] XOR ghr[S_INDEX-1:0]. The GHR, snapshots and restore are present.
- Undefined: bimodal indexing (index = fetch_pc[PC_LSB +: S_INDEX]). No GHR and no snapshot field in FIFO entries.

## Structure
- bp_pkg: state enum (INIT, RUN); pending-entry struct {index, pred, ghr}; default parameter constants.
- Sub-module bp_pending_fifo contains the circular buffer, head/tail pointers, count, full/empty, push, pop and flush. Flush takes precedence over push in the same cycle, which cannot occur given the priority rules.

## Test plan
- Reset, then idle: ctr_reset = 1 with ctr_index 0..7 over 8 cycles, fetch_ready = 0, then fetch_ready = 1 in cycle 9.
- Fetch 0x10 (counter 01): pred_taken = 0 at T+1. Resolve taken: ctr_increment at index 4, mispredict pulse, FIFO empty.
- Four fetches without resolve: fetch_ready = 0 on the 5th. One correct resolve gives fetch_ready = 1 the following cycle.
- Three in flight, oldest mispredicts: FIFO flushed. With BP_GSHARE_EN, ghr = {snapshot[1:0], actual}. The next prediction uses the restored ghr.
- resolve_valid with FIFO empty: no strobes, resolve_err = 1 and held until reset.
- fetch_valid and resolve_valid in the same cycle: resolve strobes issued, fetch_ready = 0, lookup accepted the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch direction-prediction controller.
// BP_GSHARE_EN selects gshare indexing; bimodal indexing when undefined.
package bp_pkg;

    localparam int unsigned DEF_S_INDEX = 3;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_PC_LSB  = 2;

    typedef logic [0:0] bp_state_t;
    localparam bp_state_t StInit = 1'b0;
    localparam bp_state_t StRun  = 1'b1;

    // Pending entry at the default geometry; the controller derives its own
    // parameterized variant so non-default widths stay consistent.
    typedef struct packed {
        logic [DEF_S_INDEX-1:0] index;
        logic                   pred;
        logic [DEF_S_INDEX-1:0] ghr;
    } bp_entry_t;

endpackage

// File: rtl/bp_pending_fifo.sv
// In-order buffer of in-flight predictions awaiting resolution.
// Flush empties the buffer and wins over a same-cycle push or pop.
module bp_pending_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[head_q];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[tail_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bp_direction_ctrl.sv
// Direction-prediction controller driving a 2-bit counter array (PHT).
// Define BP_GSHARE_EN for gshare indexing with a global history register.
module bp_direction_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned S_INDEX = DEF_S_INDEX,
    parameter int unsigned GHR_W   = S_INDEX,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PC_LSB  = DEF_PC_LSB
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_pc,
    output logic               fetch_ready,
    output logic               pred_valid,
    output logic               pred_taken,
    input  logic               resolve_valid,
    input  logic               resolve_taken,
    output logic               mispredict,
    output logic               resolve_err,
    output logic [S_INDEX-1:0] ctr_index,
    output logic               ctr_increment,
    output logic               ctr_decrement,
    output logic               ctr_reset,
    input  logic [1:0]         ctr_out
);

    localparam int unsigned NUM_SETS = 2 ** S_INDEX;

`ifdef BP_GSHARE_EN
    typedef struct packed {
        logic [S_INDEX-1:0] index;
        logic               pred;
        logic [GHR_W-1:0]   ghr;
    } entry_t;
`else
    typedef struct packed {
        logic [S_INDEX-1:0] index;
        logic               pred;
    } entry_t;
`endif

    bp_state_t          state_q;
    logic [S_INDEX-1:0] sweep_q;
    logic               pred_valid_q, pred_taken_q, mispredict_q, resolve_err_q;
    logic [S_INDEX-1:0] lookup_idx;
    logic               in_run, fifo_full, fifo_empty;
    logic               resolve_act, resolve_orphan, lookup_act, wrong;
    entry_t             head, push_entry;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    assign lookup_idx = fetch_pc[PC_LSB +: S_INDEX] ^ ghr_q[S_INDEX-1:0];
`else
    logic [GHR_W-1:0] unused_ghr_w;
    assign unused_ghr_w = '0;
    assign lookup_idx   = fetch_pc[PC_LSB +: S_INDEX];
`endif

    logic unused_ok;
    assign unused_ok = ^{fetch_pc, ctr_out[0]};

    assign in_run         = (state_q == StRun);
    assign resolve_act    = in_run && resolve_valid && !fifo_empty;
    assign resolve_orphan = in_run && resolve_valid && fifo_empty;
    assign fetch_ready    = in_run && !fifo_full && !(resolve_valid && !fifo_empty);
    assign lookup_act     = fetch_valid && fetch_ready;
    // Any resolve that disagrees with its prediction leaves only wrong-path entries behind.
    assign wrong          = resolve_act && (resolve_taken != head.pred);

    always_comb begin
        push_entry       = '0;
        push_entry.index = lookup_idx;
        push_entry.pred  = ctr_out[1];
`ifdef BP_GSHARE_EN
        push_entry.ghr   = ghr_q;
`endif
    end

    always_comb begin
        ctr_index     = lookup_idx;
        ctr_reset     = !in_run;
        ctr_increment = resolve_act && resolve_taken;
        ctr_decrement = resolve_act && !resolve_taken;
        if (!in_run) begin
            ctr_index = sweep_q;
        end else if (resolve_act) begin
            ctr_index = head.index;
        end
    end

    bp_pending_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (lookup_act),
        .pop   (resolve_act),
        .flush (wrong),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else if (state_q == StInit) begin
            sweep_q <= sweep_q + S_INDEX'(1);
            if (sweep_q == S_INDEX'(NUM_SETS - 1)) begin
                state_q <= StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
        end else begin
            pred_valid_q <= lookup_act;
            if (lookup_act) begin
                pred_taken_q <= ctr_out[1];
            end
            mispredict_q <= wrong;
            if (resolve_orphan) begin
                resolve_err_q <= 1'b1;
            end
        end
    end

`ifdef BP_GSHARE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (wrong) begin
            ghr_q <= {head.ghr[GHR_W-2:0], resolve_taken};
        end else if (lookup_act) begin
            ghr_q <= {ghr_q[GHR_W-2:0], ctr_out[1]};
        end
    end
`endif

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign mispredict  = mispredict_q;
    assign resolve_err = resolve_err_q;

endmodule
